im_arbiter: RTL

IM_ARBITER -- requirements
Module: im_arbiter

---
 rtl/im_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/im_arbiter.sv
// rtl/im_arbiter.sv - shared instruction-memory read port arbiter for IF fetch and LS reads
module im_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic [31:0] IM_r_addr,
  output logic        IM_r_en,
  input  logic [31:0] IM_r_data
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

  owner_t      r_owner;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_addr;

  logic w_ls_win;
  logic w_if_gnt;
  logic w_ls_gnt;

  // LS takes the port when IF is idle, being redirected, or LS has waited long enough.
  assign w_ls_win = ls_req && (!if_req || if_flush || (r_wait_cnt == LP_STARVE));
  assign w_ls_gnt = w_ls_win && !rst;
  assign w_if_gnt = if_req && !if_flush && !w_ls_win && !rst;

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign IM_r_en   = w_if_gnt || w_ls_gnt;
  assign IM_r_addr = w_if_gnt ? if_addr : (w_ls_gnt ? ls_addr : r_addr);

  // A redirect in the response cycle kills the IF data that was fetched on the old path.
  assign if_rvalid = (r_owner == OWN_IF) && !if_flush && !rst;
  assign ls_rvalid = (r_owner == OWN_LS) && !rst;
  assign if_rdata  = if_rvalid ? IM_r_data : 32'd0;
  assign ls_rdata  = ls_rvalid ? IM_r_data : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_wait_cnt <= 4'd0;
      r_addr     <= 32'd0;
    end else begin
      if (w_if_gnt) begin
        r_owner <= OWN_IF;
      end else if (w_ls_gnt) begin
        r_owner <= OWN_LS;
      end else begin
        r_owner <= OWN_NONE;
      end

      if (w_ls_gnt || !ls_req) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != LP_STARVE) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      if (IM_r_en) begin
        r_addr <= IM_r_addr;
      end
    end
  end

endmodule
